// File: rtl/hazard_controller.sv
// Pipeline sequencing controller for the 5-stage LEGv8 datapath: load-use bubbles,
// taken-branch flushes, memory-busy freeze with timeout halt, and saturating perf counters.
module hazard_controller #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 16
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [4:0]       id_rn_i,
    input  logic [4:0]       id_rm_i,
    input  logic             id_uses_rn_i,
    input  logic             id_uses_rm_i,
    input  logic [4:0]       ex_rd_i,
    input  logic             ex_regwe_i,
    input  logic             ex_memread_i,
    input  logic             ex_branch_taken_i,
    input  logic             mem_busy_i,
    output logic             pc_we_o,
    output logic             ifid_we_o,
    output logic             ifid_flush_o,
    output logic             idex_we_o,
    output logic             idex_bubble_o,
    output logic             exmem_we_o,
    output logic             memwb_we_o,
    output logic             halted_o,
    output logic             mem_err_o,
    output logic [CNT_W-1:0] stall_cycles_o,
    output logic [CNT_W-1:0] flush_count_o
);

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        WAIT = 2'd1,
        HALT = 2'd2
    } state_t;

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [7:0]       wait_cnt_q, wait_cnt_d;
    logic             mem_err_q, mem_err_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] flush_q, flush_d;
    logic             load_use;

    // XZR (X31) is never a real producer, so it can never create a hazard.
    assign load_use = ex_memread_i && ex_regwe_i && (ex_rd_i != 5'd31) &&
                      ((id_uses_rn_i && (id_rn_i == ex_rd_i)) ||
                       (id_uses_rm_i && (id_rm_i == ex_rd_i)));

    always_comb begin
        pc_we_o       = 1'b0;
        ifid_we_o     = 1'b0;
        ifid_flush_o  = 1'b0;
        idex_we_o     = 1'b0;
        idex_bubble_o = 1'b0;
        exmem_we_o    = 1'b0;
        memwb_we_o    = 1'b0;
        halted_o      = 1'b0;
        if (!reset_i) begin
            unique case (state_q)
                RUN, WAIT: begin
                    if (!mem_busy_i) begin
                        pc_we_o    = 1'b1;
                        ifid_we_o  = 1'b1;
                        idex_we_o  = 1'b1;
                        exmem_we_o = 1'b1;
                        memwb_we_o = 1'b1;
                        if (ex_branch_taken_i) begin
                            ifid_flush_o  = 1'b1;
                            idex_bubble_o = 1'b1;
                        end else if (load_use) begin
                            pc_we_o       = 1'b0;
                            ifid_we_o     = 1'b0;
                            idex_bubble_o = 1'b1;
                        end
                    end
                end
                HALT:    halted_o = 1'b1;
                default: halted_o = 1'b0;
            endcase
        end
    end

    assign mem_err_o      = mem_err_q;
    assign stall_cycles_o = stall_q;
    assign flush_count_o  = flush_q;

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        mem_err_d  = mem_err_q;
        stall_d    = stall_q;
        flush_d    = flush_q;
        unique case (state_q)
            RUN: begin
                if (mem_busy_i) begin
                    state_d    = WAIT;
                    wait_cnt_d = 8'd1;
                end
            end
            WAIT: begin
                if (!mem_busy_i) begin
                    state_d    = RUN;
                    wait_cnt_d = 8'd0;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d   = HALT;
                    mem_err_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            default: state_d = HALT;
        endcase
        // HALT drives pc_we low too, but those cycles are not stalls.
        if ((state_q != HALT) && !pc_we_o && (stall_q != '1)) begin
            stall_d = stall_q + 1'b1;
        end
        if (ifid_flush_o && (flush_q != '1)) begin
            flush_d = flush_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= RUN;
            wait_cnt_q <= 8'd0;
            mem_err_q  <= 1'b0;
            stall_q    <= '0;
            flush_q    <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            mem_err_q  <= mem_err_d;
            stall_q    <= stall_d;
            flush_q    <= flush_d;
        end
    end

endmodule

// File: tb/tb_hazard_controller.sv
// Directed and randomized checks of hazard_controller against a cycle-level model
// that tracks consecutive busy cycles and halt status rather than FSM states.
module tb_hazard_controller;

    localparam int TIMEOUT = 4;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset;
    logic [4:0]       idRn, idRm, exRd;
    logic             idUsesRn, idUsesRm, exRegwe, exMemread, exBranchTaken, memBusy;
    logic             pcWe, ifidWe, ifidFlush, idexWe, idexBubble, exmemWe, memwbWe;
    logic             halted, memErr;
    logic [CNT_W-1:0] stallCycles, flushCount;

    int checks = 0;
    int errors = 0;

    // Reference model state: plain counts rather than an FSM encoding.
    int mStall, mFlush, mBusyRun;
    bit mHalted, mMemErr, mInReset;

    hazard_controller #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk_i            (clk),
        .reset_i          (reset),
        .id_rn_i          (idRn),
        .id_rm_i          (idRm),
        .id_uses_rn_i     (idUsesRn),
        .id_uses_rm_i     (idUsesRm),
        .ex_rd_i          (exRd),
        .ex_regwe_i       (exRegwe),
        .ex_memread_i     (exMemread),
        .ex_branch_taken_i(exBranchTaken),
        .mem_busy_i       (memBusy),
        .pc_we_o          (pcWe),
        .ifid_we_o        (ifidWe),
        .ifid_flush_o     (ifidFlush),
        .idex_we_o        (idexWe),
        .idex_bubble_o    (idexBubble),
        .exmem_we_o       (exmemWe),
        .memwb_we_o       (memwbWe),
        .halted_o         (halted),
        .mem_err_o        (memErr),
        .stall_cycles_o   (stallCycles),
        .flush_count_o    (flushCount)
    );

    always #5 clk = ~clk;

    function automatic bit loadUse();
        return exMemread && exRegwe && (exRd != 5'd31) &&
               ((idUsesRn && idRn == exRd) || (idUsesRm && idRm == exRd));
    endfunction

    // Order: pc, ifid_we, ifid_flush, idex_we, idex_bubble, exmem, memwb, halted, mem_err
    function automatic logic [8:0] expectedCtrl();
        if (mInReset)      return 9'b0;
        if (mHalted)       return {7'b0000000, 1'b1, mMemErr};
        if (memBusy)       return {7'b0000000, 1'b0, mMemErr};
        if (exBranchTaken) return {7'b1111111, 1'b0, mMemErr};
        if (loadUse())     return {7'b0001111, 1'b0, mMemErr};
        return {7'b1101011, 1'b0, mMemErr};
    endfunction

    function automatic int satInc(int v);
        return (v >= CNT_MAX) ? CNT_MAX : v + 1;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic checkAll(input string tag);
        checkOutput({tag, "_ctrl"}, 32'({pcWe, ifidWe, ifidFlush, idexWe, idexBubble,
                                         exmemWe, memwbWe, halted, memErr}), 32'(expectedCtrl()));
        checkOutput({tag, "_stall"}, 32'(stallCycles), 32'(mStall));
        checkOutput({tag, "_flush"}, 32'(flushCount), 32'(mFlush));
    endtask

    task automatic advanceModel();
        if (mHalted) return;
        if (memBusy) begin
            mStall = satInc(mStall);
            mBusyRun++;
            if (mBusyRun == TIMEOUT) begin
                mHalted = 1'b1;
                mMemErr = 1'b1;
            end
        end else begin
            mBusyRun = 0;
            if (exBranchTaken)  mFlush = satInc(mFlush);
            else if (loadUse()) mStall = satInc(mStall);
        end
    endtask

    // One clock cycle: drive at negedge, check just after, update the model at posedge.
    task automatic applyStimulus(input logic [4:0] rn, input logic [4:0] rm, input logic usesRn,
                                 input logic usesRm, input logic [4:0] rd, input logic regwe,
                                 input logic memread, input logic branch, input logic busy,
                                 input string tag);
        @(negedge clk);
        idRn = rn; idRm = rm; idUsesRn = usesRn; idUsesRm = usesRm;
        exRd = rd; exRegwe = regwe; exMemread = memread;
        exBranchTaken = branch; memBusy = busy;
        #1;
        checkAll(tag);
        @(posedge clk);
        advanceModel();
    endtask

    task automatic idleCycle(input string tag);
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, tag);
    endtask

    task automatic resetDut(input string tag);
        @(negedge clk);
        reset = 1'b1;
        idRn = '0; idRm = '0; idUsesRn = 0; idUsesRm = 0; exRd = '0;
        exRegwe = 0; exMemread = 0; exBranchTaken = 0; memBusy = 0;
        mInReset = 1'b1;
        mStall = 0; mFlush = 0; mBusyRun = 0; mHalted = 0; mMemErr = 0;
        #1;
        checkAll(tag);
        @(negedge clk);
        reset = 1'b0;
        mInReset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        mInReset = 1'b1;
        resetDut("reset0");

        // Load-use on X2: one bubble, then free flow.
        applyStimulus(5'd2, 5'd7, 1'b1, 1'b0, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0, "t1_lu");
        applyStimulus(5'd2, 5'd7, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, "t1_after");
        checkOutput("t1_stall_const", 32'(stallCycles), 32'd1);
        applyStimulus(5'd9, 5'd4, 1'b0, 1'b1, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0, "t1_lu_rm");
        applyStimulus(5'd9, 5'd4, 1'b0, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, "t1_no_load");

        // XZR never stalls.
        resetDut("reset2");
        applyStimulus(5'd31, 5'd0, 1'b1, 1'b0, 5'd31, 1'b1, 1'b1, 1'b0, 1'b0, "t2_xzr");
        idleCycle("t2_idle");
        checkOutput("t2_stall_const", 32'(stallCycles), 32'd0);

        // Branch wins over load-use.
        resetDut("reset3");
        applyStimulus(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, "t3_br_lu");
        idleCycle("t3_idle");
        checkOutput("t3_flush_const", 32'(flushCount), 32'd1);
        checkOutput("t3_stall_const", 32'(stallCycles), 32'd0);

        // Freeze defers the branch flush until memory is ready.
        resetDut("reset4");
        for (int i = 0; i < 3; i++)
            applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, "t4_busy");
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, "t4_flush");
        idleCycle("t4_idle");
        checkOutput("t4_stall_const", 32'(stallCycles), 32'd3);
        checkOutput("t4_flush_const", 32'(flushCount), 32'd1);

        // Timeout to HALT, which only reset leaves.
        resetDut("reset5");
        for (int i = 0; i < TIMEOUT; i++)
            applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, "t5_busy");
        applyStimulus(5'd3, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0, "t5_halt");
        checkOutput("t5_halted_const", 32'({halted, memErr}), 32'd3);
        idleCycle("t5_halt2");
        resetDut("t5_reset");
        checkOutput("t5_cleared_const", 32'({halted, memErr, stallCycles, flushCount}), 32'd0);

        // Reset mid-WAIT clears the wait progress.
        for (int i = 0; i < TIMEOUT - 1; i++)
            applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, "t7_busy");
        resetDut("t7_reset");
        for (int i = 0; i < TIMEOUT - 1; i++)
            applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, "t7_busy2");
        idleCycle("t7_resume");

        // Stall counter saturation.
        resetDut("reset6");
        for (int i = 0; i < (1 << CNT_W) + 5; i++)
            applyStimulus(5'd8, 5'd0, 1'b1, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0, "t6_lu");
        idleCycle("t6_idle");
        checkOutput("t6_sat_const", 32'(stallCycles), 32'(CNT_MAX));
        for (int i = 0; i < (1 << CNT_W) + 2; i++)
            applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, "t6_br");
        idleCycle("t6_idle2");
        checkOutput("t6_flush_sat_const", 32'(flushCount), 32'(CNT_MAX));

        // Randomized traffic with small register indices so hazards are frequent.
        resetDut("reset_rand");
        for (int i = 0; i < 400; i++) begin
            if (i % 60 == 59) resetDut("rand_reset");
            else applyStimulus(
                ($urandom_range(0, 4) == 0) ? 5'd31 : 5'($urandom_range(0, 3)),
                5'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 4) == 0) ? 5'd31 : 5'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) == 0),
                "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_controller.md
Name: hazard_controller

Overview:
Pipeline sequencing controller for the 5-stage LEGv8 datapath. It sits beside the forwarding unit. It detects load-use hazards the forwarding paths cannot cover and inserts a single bubble. It flushes IF/ID and ID/EX on a taken branch resolved in EX. It freezes the whole pipeline while the data memory reports busy, with a timeout that halts the core, and it keeps saturating stall and flush performance counters.

Parameters:
TIMEOUT, 16, consecutive mem_busy cycles before the controller halts (range 2..255)
CNT_W, 16, width of each performance counter

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high
id_rn  in  5  Rn field of the instruction in ID
id_rm  in  5  Rm field of the instruction in ID
id_uses_rn  in  1  ID instruction reads Rn
id_uses_rm  in  1  ID instruction reads Rm
ex_rd  in  5  destination register of the instruction in EX
ex_regwe  in  1  EX instruction writes the register file
ex_memread  in  1  EX instruction is a load
ex_branch_taken  in  1  branch resolved taken in EX this cycle
mem_busy  in  1  data memory not ready; MEM stage must hold
pc_we  out  1  PC write enable
ifid_we  out  1  IF/ID write enable
ifid_flush  out  1  load NOP into IF/ID
idex_we  out  1  ID/EX write enable
idex_bubble  out  1  load NOP (all control bits 0) into ID/EX
exmem_we  out  1  EX/MEM write enable
memwb_we  out  1  MEM/WB write enable
halted  out  1  controller is in HALT
mem_err  out  1  sticky memory timeout flag
stall_cycles  out  CNT_W  cycles with pc_we=0 while not in reset or HALT; saturating
flush_count  out  CNT_W  taken-branch flush events; saturating

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-high.
- States: RUN, WAIT, HALT. Reset puts the block in RUN with wait_cnt=0, counters=0, mem_err=0.
- While reset is high, all outputs are 0.
- Outputs are combinational from state and inputs (Mealy). State and counters update on the rising edge of clk.
- Load-use condition (lu): ex_memread & ex_regwe & ex_rd!=31 & ((id_uses_rn & id_rn==ex_rd) | (id_uses_rm & id_rm==ex_rd)). X31 (XZR) never causes a hazard.
- Default outputs in RUN, or in WAIT once mem_busy=0: all *_we=1, flush=0, bubble=0.
- Priority 1, mem_busy=1 in RUN or WAIT: all five *_we=0, ifid_flush=0, idex_bubble=0 (full freeze). ex_branch_taken and lu are ignored and are re-evaluated after the freeze.
- Priority 2, ex_branch_taken=1: ifid_flush=1, idex_bubble=1, pc_we=1 (the PC loads the branch target). This overrides lu. flush_count increments.
- Priority 3, lu=1: pc_we=0, ifid_we=0, idex_bubble=1, exmem_we=1, memwb_we=1. The bubble then sits in EX, so lu deasserts the next cycle. Exactly one bubble per load-use.
- RUN to WAIT when mem_busy=1; wait_cnt<=1.
- WAIT while mem_busy=1: wait_cnt increments. When wait_cnt==TIMEOUT-1 and mem_busy=1, the next state is HALT and mem_err<=1.
- WAIT to RUN when mem_busy=0; wait_cnt<=0. Outputs in that cycle follow priorities 2 and 3.
- HALT: all *_we=0, flush=0, bubble=0, halted=1. The block stays in HALT until reset; all inputs are ignored.
- stall_cycles increments on each cycle with pc_we=0, excluding reset and HALT. It saturates at all-ones.
- flush_count saturates at all-ones.
- Reset asserted mid-WAIT: the block returns to RUN at once, wait_cnt=0, and mem_err clears.

Test Plan:
1. LDUR X2 in EX (ex_rd=2, memread=1, regwe=1) with ADD reading id_rn=2 -> exactly one cycle with pc_we=0, ifid_we=0, idex_bubble=1; next cycle all enables 1; stall_cycles=1.
2. Same as test 1 but ex_rd=31 and id_rn=31 -> no stall; stall_cycles stays 0.
3. ex_branch_taken=1 together with lu=1 -> ifid_flush=1, idex_bubble=1, pc_we=1; flush_count=1; stall_cycles=0.
4. mem_busy high for 3 cycles with ex_branch_taken=1 -> three cycles with all *_we=0 and no flush. On the 4th cycle (mem_busy=0) the flush occurs; stall_cycles=3.
5. mem_busy held high with TIMEOUT=4 -> freeze for 4 cycles, then halted=1 and mem_err=1. The block stays in HALT after mem_busy drops; asserting reset clears halted, mem_err and both counters.
6. 2^CNT_W+5 load-use stalls (CNT_W=4 for speed) -> stall_cycles saturates at 15 and does not wrap.
